// File: rtl/nurn_mem_loader.sv
// Packet-driven writer for the neuron config/status memories.
// A header word selects target, base and length; the data words that follow become sequential writes.
module nurn_mem_loader #(
  parameter int NUM_NURNS          = 4,
  parameter int NUM_AXONS          = 4,
  parameter int NURN_CNT_BIT_WIDTH = 2,
  parameter int AXON_CNT_BIT_WIDTH = 2,
  parameter int DATA_WIDTH         = 16
) (
  input  logic                                             clk_i,
  input  logic                                             rst_n_i,
  input  logic                                             pkt_valid_i,
  input  logic [DATA_WIDTH-1:0]                            pkt_data_i,
  output logic                                             pkt_ready_o,
  input  logic                                             nurn_busy_i,
  output logic                                             load_busy_o,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0]                            wr_data_o,
  output logic                                             wrEn_Config_A_o,
  output logic                                             wrEn_Config_B_o,
  output logic                                             wrEn_Config_C_o,
  output logic                                             wrEn_StatNurn_o,
  output logic                                             wrEn_StatWt_o,
  output logic                                             done_o,
  output logic                                             err_o
);

  localparam int ADDR_W = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;

  localparam logic [1:0] HDR_S   = 2'd0;
  localparam logic [1:0] DATA_S  = 2'd1;
  localparam logic [1:0] DRAIN_S = 2'd2;

  localparam logic [2:0] SEL_CFGA     = 3'd0;
  localparam logic [2:0] SEL_CFGB     = 3'd1;
  localparam logic [2:0] SEL_CFGC     = 3'd2;
  localparam logic [2:0] SEL_STATNURN = 3'd3;
  localparam logic [2:0] SEL_STATWT   = 3'd4;

  // Last legal address per target, held one bit wider than an address so the range check cannot wrap
  localparam int LAST_NURN_I = NUM_NURNS - 1;
  localparam int LAST_AXON_I = NUM_NURNS * NUM_AXONS - 1;
  localparam int LAST_STAT_I = NUM_NURNS * 4 - 1;
  localparam logic [ADDR_W:0] LAST_NURN = LAST_NURN_I[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST_AXON = LAST_AXON_I[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST_STAT = LAST_STAT_I[ADDR_W:0];

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [2:0]            sel;
  logic [ADDR_W-1:0]     base;
  logic [ADDR_W-1:0]     lenM1;
  logic [ADDR_W-1:0]     cnt;
  logic [4:0]            wrEn;
  logic [ADDR_W-1:0]     wrAddr;
  logic [DATA_WIDTH-1:0] wrData;
  logic                  done;
  logic                  err;

  logic [2:0]        hdrSel;
  logic [ADDR_W-1:0] hdrBase;
  logic [ADDR_W-1:0] hdrLenM1;
  logic [ADDR_W:0]   hdrEnd;
  logic [ADDR_W:0]   hdrLast;
  logic              hdrSelOk;
  logic              hdrLegal;
  logic              pktReady;
  logic              pktFire;
  logic [4:0]        selOneHot;

  assign hdrSel   = pkt_data_i[2:0];
  assign hdrBase  = pkt_data_i[3+ADDR_W-1:3];
  assign hdrLenM1 = pkt_data_i[3+2*ADDR_W-1:3+ADDR_W];
  assign hdrEnd   = {1'b0, hdrBase} + {1'b0, hdrLenM1};

  always_comb begin
    hdrLast  = '0;
    hdrSelOk = 1'b1;
    case (hdrSel)
      SEL_CFGA, SEL_CFGB:   hdrLast = LAST_NURN;
      SEL_CFGC, SEL_STATWT: hdrLast = LAST_AXON;
      SEL_STATNURN:         hdrLast = LAST_STAT;
      default:              hdrSelOk = 1'b0;
    endcase
  end

  assign hdrLegal = hdrSelOk && (hdrEnd <= hdrLast);

  // Only the data phase yields to the neuron controller; header and drain words always flow
  always_comb begin
    pktReady = 1'b1;
    if (state == DATA_S) pktReady = ~nurn_busy_i;
  end

  assign pktFire = pkt_valid_i & pktReady;

  always_comb begin
    selOneHot = '0;
    case (sel)
      SEL_CFGA:     selOneHot[0] = 1'b1;
      SEL_CFGB:     selOneHot[1] = 1'b1;
      SEL_CFGC:     selOneHot[2] = 1'b1;
      SEL_STATNURN: selOneHot[3] = 1'b1;
      SEL_STATWT:   selOneHot[4] = 1'b1;
      default:      selOneHot = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= HDR_S;
      sel    <= '0;
      base   <= '0;
      lenM1  <= '0;
      cnt    <= '0;
      wrEn   <= '0;
      wrAddr <= '0;
      wrData <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      wrEn <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        HDR_S: begin
          if (pktFire) begin
            sel   <= hdrSel;
            base  <= hdrBase;
            lenM1 <= hdrLenM1;
            cnt   <= '0;
            if (hdrLegal) begin
              state <= DATA_S;
            end else begin
              state <= DRAIN_S;
              err   <= 1'b1;
            end
          end
        end
        DATA_S: begin
          if (pktFire) begin
            wrAddr <= base + cnt;
            wrData <= pkt_data_i;
            wrEn   <= selOneHot;
            cnt    <= cnt + ADDR_ONE;
            if (cnt == lenM1) begin
              state <= HDR_S;
              done  <= 1'b1;
            end
          end
        end
        DRAIN_S: begin
          if (pktFire) begin
            cnt <= cnt + ADDR_ONE;
            if (cnt == lenM1) state <= HDR_S;
          end
        end
        default: state <= HDR_S;
      endcase
    end
  end

  // The done cycle still counts as owned so the last write completes before the controller may start
  assign load_busy_o     = (state == DATA_S) | done;
  assign pkt_ready_o     = pktReady;
  assign wr_addr_o       = wrAddr;
  assign wr_data_o       = wrData;
  assign wrEn_Config_A_o = wrEn[0];
  assign wrEn_Config_B_o = wrEn[1];
  assign wrEn_Config_C_o = wrEn[2];
  assign wrEn_StatNurn_o = wrEn[3];
  assign wrEn_StatWt_o   = wrEn[4];
  assign done_o          = done;
  assign err_o           = err;

endmodule

// File: tb/tb_nurn_mem_loader.sv
// Randomized bench for nurn_mem_loader; packets are scored against a per-packet write list
// derived from target depths, with directed cases for stalls, illegal headers and mid-packet reset.
module tb_nurn_mem_loader;

  localparam int NUM_NURNS = 4;
  localparam int NUM_AXONS = 4;
  localparam int DW        = 16;
  localparam int AW        = 4;

  logic          clk_i       = 1'b0;
  logic          rst_n_i     = 1'b0;
  logic          pkt_valid_i = 1'b0;
  logic [DW-1:0] pkt_data_i  = '0;
  logic          nurn_busy_i = 1'b0;
  logic          pkt_ready_o;
  logic          load_busy_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          wrEn_Config_A_o;
  logic          wrEn_Config_B_o;
  logic          wrEn_Config_C_o;
  logic          wrEn_StatNurn_o;
  logic          wrEn_StatWt_o;
  logic          done_o;
  logic          err_o;

  int checks = 0;
  int fails  = 0;
  bit randBusy = 1'b0;
  bit randGaps = 1'b0;

  logic [4:0]  expWrEn     = '0;
  logic [31:0] expAddr     = '0;
  logic [31:0] expData     = '0;
  bit          doneDue     = 1'b0;
  bit          errDue      = 1'b0;
  bit          expLoadBusy = 1'b0;

  nurn_mem_loader #(
    .NUM_NURNS(NUM_NURNS), .NUM_AXONS(NUM_AXONS),
    .NURN_CNT_BIT_WIDTH(2), .AXON_CNT_BIT_WIDTH(2), .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .pkt_valid_i(pkt_valid_i), .pkt_data_i(pkt_data_i), .pkt_ready_o(pkt_ready_o),
    .nurn_busy_i(nurn_busy_i), .load_busy_o(load_busy_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .wrEn_Config_A_o(wrEn_Config_A_o), .wrEn_Config_B_o(wrEn_Config_B_o),
    .wrEn_Config_C_o(wrEn_Config_C_o), .wrEn_StatNurn_o(wrEn_StatNurn_o),
    .wrEn_StatWt_o(wrEn_StatWt_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int depthOf(input int sel);
    case (sel)
      0, 1:    return NUM_NURNS;
      2, 4:    return NUM_NURNS * NUM_AXONS;
      3:       return NUM_NURNS * 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit isLegal(input int sel, input int base, input int lenM1);
    return (depthOf(sel) > 0) && (base + lenM1 <= depthOf(sel) - 1);
  endfunction

  // Compares the registered outputs against what the previous clock edge should have produced
  task automatic monitorStep();
    logic [4:0] wrVec;
    if (rst_n_i) begin
      wrVec = {wrEn_StatWt_o, wrEn_StatNurn_o, wrEn_Config_C_o, wrEn_Config_B_o, wrEn_Config_A_o};
      checkOutput("wrEn", 32'(wrVec), 32'(expWrEn));
      if (expWrEn != 5'd0) begin
        checkOutput("wrAddr", 32'(wr_addr_o), expAddr);
        checkOutput("wrData", 32'(wr_data_o), expData);
      end
      checkOutput("done", 32'(done_o), 32'(doneDue));
      checkOutput("err", 32'(err_o), 32'(errDue));
      checkOutput("loadBusy", 32'(load_busy_o), 32'(expLoadBusy));
      if (doneDue) expLoadBusy = 1'b0;
    end
    expWrEn = '0;
    doneDue = 1'b0;
    errDue  = 1'b0;
  endtask

  task automatic nextNegedge();
    @(negedge clk_i);
    monitorStep();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      nextNegedge();
      pkt_valid_i = 1'b0;
      nurn_busy_i = randBusy ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  endtask

  // kind: 0 header, 1 data of a legal packet, 2 drained data
  task automatic applyStimulus(input logic [DW-1:0] d, input int kind, input int stallCycles,
                               output bit taken);
    int   waits;
    int   stallLeft;
    logic rdy;
    waits     = 0;
    stallLeft = stallCycles;
    taken     = 1'b0;
    while (!taken && waits < 64) begin
      nextNegedge();
      pkt_valid_i = 1'b1;
      pkt_data_i  = d;
      if (stallLeft > 0) begin
        nurn_busy_i = 1'b1;
        stallLeft--;
      end else if (randBusy) begin
        nurn_busy_i = ($urandom_range(0, 3) == 0);
      end else begin
        nurn_busy_i = 1'b0;
      end
      #1;
      rdy = pkt_ready_o;
      checkOutput(kind == 0 ? "hdrReady" : (kind == 1 ? "dataReady" : "drainReady"),
                  32'(rdy), 32'((kind == 1) ? !nurn_busy_i : 1'b1));
      @(posedge clk_i);
      if (rdy) taken = 1'b1;
      else waits++;
    end
    if (!taken) checkOutput("handshake", 32'(taken), 32'(1));
  endtask

  task automatic sendPacket(input int sel, input int base, input int lenM1, input bit altData,
                            input int stallAt, input int stallLen);
    logic [DW-1:0] hdr;
    logic [DW-1:0] d;
    bit            legal;
    bit            taken;
    legal = isLegal(sel, base, lenM1);
    hdr = DW'($urandom);
    hdr[2:0]       = 3'(sel);
    hdr[3+:AW]     = AW'(base);
    hdr[3+AW+:AW]  = AW'(lenM1);
    applyStimulus(hdr, 0, 0, taken);
    if (!taken) return;
    if (legal) expLoadBusy = 1'b1;
    else errDue = 1'b1;
    for (int i = 0; i <= lenM1; i++) begin
      if (randGaps && $urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
      d = altData ? ((i % 2 == 0) ? DW'(1) : DW'(0)) : DW'($urandom);
      applyStimulus(d, legal ? 1 : 2, (i == stallAt) ? stallLen : 0, taken);
      if (!taken) return;
      if (legal) begin
        expWrEn = 5'(1 << sel);
        expAddr = 32'(base + i);
        expData = 32'(d);
        if (i == lenM1) doneDue = 1'b1;
      end
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "WrEn"}, 32'({wrEn_StatWt_o, wrEn_StatNurn_o, wrEn_Config_C_o,
                                   wrEn_Config_B_o, wrEn_Config_A_o}), 32'(0));
    checkOutput({tag, "Addr"}, 32'(wr_addr_o), 32'(0));
    checkOutput({tag, "Data"}, 32'(wr_data_o), 32'(0));
    checkOutput({tag, "Done"}, 32'(done_o), 32'(0));
    checkOutput({tag, "Err"}, 32'(err_o), 32'(0));
    checkOutput({tag, "LoadBusy"}, 32'(load_busy_o), 32'(0));
    checkOutput({tag, "Ready"}, 32'(pkt_ready_o), 32'(1));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] hdr;
    logic [DW-1:0] d;
    bit            taken;

    #12;
    checkResetState("rst");
    @(negedge clk_i);
    #2 rst_n_i = 1'b1;
    idleCycles(2);

    sendPacket(1, 0, 3, 1'b1, -1, 0);
    sendPacket(3, 5, 2, 1'b0, -1, 0);
    sendPacket(4, 14, 2, 1'b0, -1, 0);
    sendPacket(2, 3, 5, 1'b0, 2, 5);
    sendPacket(6, 0, 2, 1'b0, -1, 0);
    sendPacket(0, 0, 3, 1'b0, -1, 0);
    idleCycles(2);

    // Abandon a 16-word weight packet part-way through
    hdr = '0;
    hdr[2:0]      = 3'd4;
    hdr[3+AW+:AW] = 4'd15;
    applyStimulus(hdr, 0, 0, taken);
    expLoadBusy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = DW'($urandom);
      applyStimulus(d, 1, 0, taken);
      expWrEn = 5'b10000;
      expAddr = 32'(i);
      expData = 32'(d);
    end
    #1 rst_n_i = 1'b0;
    pkt_valid_i = 1'b0;
    #1 checkResetState("midRst");
    expWrEn = '0;
    doneDue = 1'b0;
    errDue = 1'b0;
    expLoadBusy = 1'b0;
    idleCycles(2);
    #2 rst_n_i = 1'b1;
    sendPacket(0, 1, 2, 1'b0, -1, 0);
    idleCycles(2);

    randBusy = 1'b1;
    randGaps = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int sel;
      int base;
      int lenM1;
      int dep;
      sel = ($urandom_range(0, 4) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      dep = depthOf(sel);
      if (dep > 0 && $urandom_range(0, 2) != 0) begin
        base  = $urandom_range(0, dep - 1);
        lenM1 = $urandom_range(0, dep - 1 - base);
      end else begin
        base  = $urandom_range(0, 15);
        lenM1 = $urandom_range(0, 15);
      end
      sendPacket(sel, base, lenM1, 1'b0, -1, 0);
    end
    randBusy = 1'b0;
    randGaps = 1'b0;
    idleCycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/nurn_mem_loader.md
Name: nurn_mem_loader

Overview:
- Writer-side counterpart of the neuron controller's config/status memory read ports.
- Accepts a valid/ready word stream from the NoC packet interface. Each packet is one header word followed by N data words.
- Decodes a target memory, base address and length from the header, then issues sequential writes to the neuron's config or status memories.
- Interlocks with the neuron controller so that no write lands while a recall/learn pass is running.

Parameters:
- NUM_NURNS, 4, neurons per core.
- NUM_AXONS, 4, axons per neuron.
- NURN_CNT_BIT_WIDTH, 2, neuron index width.
- AXON_CNT_BIT_WIDTH, 2, axon index width; must be >= 2.
- DATA_WIDTH, 16, stream and memory word width; must be >= 3+2*ADDR_W.
- ADDR_W (localparam), NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH, write address width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  async active-low reset
- pkt_valid_i  in  1  stream word valid
- pkt_data_i  in  DATA_WIDTH  stream word
- pkt_ready_o  out  1  stream word accepted when valid&ready
- nurn_busy_i  in  1  neuron controller not idle (recall or learn FSM active)
- load_busy_o  out  1  loader owns memories; controller start is gated by this
- wr_addr_o  out  ADDR_W  write address, LSB-aligned to target depth
- wr_data_o  out  DATA_WIDTH  write data
- wrEn_Config_A_o  out  1  bias-learn-mode config write
- wrEn_Config_B_o  out  1  neuron-type config write
- wrEn_Config_C_o  out  1  axon-learn-mode config write
- wrEn_StatNurn_o  out  1  per-neuron status write (bias/memb pot/th/post hist)
- wrEn_StatWt_o  out  1  weight status write
- done_o  out  1  1-cycle pulse: packet fully written
- err_o  out  1  1-cycle pulse: packet rejected

Behaviour:
- Reset: all outputs 0, except pkt_ready_o=1 in HDR_S. FSM goes to HDR_S; counters, address and length are cleared. Reset mid-packet abandons the packet with no further writes; the upstream sender is responsible for resynchronisation.
- Header word fields:
  - sel = [2:0]: 0 cfgA, 1 cfgB, 2 cfgC, 3 statNurn, 4 statWt, 5-7 reserved.
  - base = [3+ADDR_W-1:3].
  - len_m1 = [3+2*ADDR_W-1:3+ADDR_W]; word count = len_m1+1.
  - Upper bits are ignored.
- Target depth: cfgA/cfgB = NUM_NURNS; cfgC/statWt = NUM_NURNS*NUM_AXONS; statNurn = NUM_NURNS*4, addressed as {nurn,2'bxx}.
- Range check: computed in ADDR_W+1 bits. Legal iff sel<=4 and base+len_m1 <= depth-1. No address wrap ever occurs.
- HDR_S:
  - pkt_ready_o=1. On handshake, latch sel/base/len_m1 and clear the word counter.
  - Legal header -> DATA_S, load_busy_o=1.
  - Illegal header -> DRAIN_S and err_o pulses the next cycle.
- DATA_S:
  - pkt_ready_o = ~nurn_busy_i (combinational). While busy, stall and issue no writes.
  - Each handshake registers wr_addr_o=base+cnt, wr_data_o=pkt_data_i and the one-hot wrEn for sel, all valid the following cycle (1-cycle latency). cnt then increments.
  - On the handshake with cnt==len_m1 -> HDR_S. Final write and done_o are asserted together the next cycle; load_busy_o deasserts after that cycle.
- DRAIN_S:
  - pkt_ready_o=1; data is discarded with no wrEn.
  - Consumes len_m1+1 words, then -> HDR_S. load_busy_o stays 0.
- wrEn outputs are one-hot or all-zero, asserted for exactly 1 cycle per accepted word.
- Back-to-back packets are allowed. A header is accepted the cycle after the last data word, and its DATA_S writes never overlap the previous done_o cycle incorrectly.
- If nurn_busy_i and load_busy_o are both high, the loader yields (stalls). No error is raised.
- Writes to reserved addresses inside legal depth are permitted; content meaning is owned by the datapath.

Test Plan:
- Header sel=1, base=0, len_m1=3, then data 0x1,0x0,0x1,0x0 with nurn_busy_i=0 -> wrEn_Config_B_o 4 cycles, addr 0..3, data matches, done_o on the 4th write cycle, pkt_ready_o stays 1.
- Header sel=3, base=5, len_m1=2 (addrs 5,6,7 = nurn1 membPot/th/hist) -> wrEn_StatNurn_o at addr 5,6,7, no other wrEn.
- Header sel=4, base=14, len_m1=2 (14+2 > 15) -> err_o pulse, 3 data words drained with no wrEn, next header accepted normally.
- sel=2 packet, nurn_busy_i=1 after the 2nd data word for 5 cycles -> pkt_ready_o=0 for 5 cycles, no wrEn, remaining writes resume at addr base+2; load_busy_o held high throughout.
- Header sel=6 -> err_o, drain of len_m1+1 words.
- Assert rst_n_i low mid-DATA_S of a 16-word statWt packet -> all outputs 0 immediately, after release FSM in HDR_S and a fresh sel=0 packet writes correctly.
